// File: rtl/mult_seq_nxn_if.sv
// Operand/handshake bundle for the sequential NxN multiplier.
// The master drives a request with its operands; the slave reports busy/done and the product.
interface mult_seq_nxn_if #(
  parameter int N = 4
);
  logic           start;
  logic           sgn;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] out;

  modport master (output start, sgn, a, b, input busy, done, out);
  modport slave  (input start, sgn, a, b, output busy, done, out);
endinterface

// File: rtl/mult_seq_nxn.sv
// Sequential NxN shift-add multiplier with unsigned and two's-complement modes.
// Signed operands are reduced to magnitudes at capture; the sign is reapplied
// to the final sum, so the core loop only ever does unsigned adds.
//
// state | meaning
// IDLE  | waiting for start, busy=0, product held
// CALC  | one multiplier bit consumed per clock, N clocks total
module mult_seq_nxn #(
  parameter int N = 4
) (
  input logic           Clk,
  input logic           rst,
  mult_seq_nxn_if.slave bus
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t state, state_nxt;

  logic [N-1:0]   ma;
  logic [N-1:0]   mb;
  logic           neg;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] out_r;
  logic           done_r;

  logic           capture;
  logic           last_step;
  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [2*N-1:0] partial;
  logic [2*N-1:0] acc_sum;

  // Most-negative input maps to 2^(N-1), which still fits as an N-bit unsigned magnitude.
  assign mag_a = (bus.sgn && bus.a[N-1]) ? (~bus.a + 1'b1) : bus.a;
  assign mag_b = (bus.sgn && bus.b[N-1]) ? (~bus.b + 1'b1) : bus.b;

  assign capture   = (state == IDLE) && bus.start;
  assign last_step = (state == CALC) && (cnt == CW'(N - 1));
  assign partial   = mb[0] ? ({{N{1'b0}}, ma} << cnt) : '0;
  assign acc_sum   = acc + partial;

  // State register.
  always_ff @(posedge Clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept a request in IDLE, return after the Nth step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = CALC;
      CALC: if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and result/done registration.
  always_ff @(posedge Clk) begin
    if (rst) begin
      ma     <= '0;
      mb     <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      out_r  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (capture) begin
        ma  <= mag_a;
        mb  <= mag_b;
        neg <= bus.sgn & (bus.a[N-1] ^ bus.b[N-1]);
        acc <= '0;
        cnt <= '0;
      end else if (state == CALC) begin
        acc <= acc_sum;
        mb  <= mb >> 1;
        cnt <= cnt + CW'(1);
        if (last_step) begin
          out_r  <= neg ? (~acc_sum + 1'b1) : acc_sum;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state == CALC);
  assign bus.done = done_r;
  assign bus.out  = out_r;

endmodule

// File: tb/tb_mult_seq_nxn.sv
// Directed bench for mult_seq_nxn at N=4 and N=8; inputs driven and outputs sampled on the falling edge.
module tb_mult_seq_nxn;

  logic Clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  mult_seq_nxn_if #(.N(4)) m4 ();
  mult_seq_nxn_if #(.N(8)) m8 ();

  mult_seq_nxn #(.N(4)) dut4 (.Clk(Clk), .rst(rst), .bus(m4));
  mult_seq_nxn #(.N(8)) dut8 (.Clk(Clk), .rst(rst), .bus(m8));

  task automatic wait_done4(output int got, output int busy_cyc);
    int cyc;
    got = 0; busy_cyc = 0; cyc = 0;
    while (cyc < 20 && got == 0) begin
      if (m4.done === 1'b1) got = 1;
      else begin
        if (m4.busy === 1'b1) busy_cyc++;
        @(negedge Clk);
        cyc++;
      end
    end
  endtask

  task automatic run4(input logic s, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] exp, input string name);
    int got, bc;
    @(negedge Clk);
    m4.start = 1'b1; m4.sgn = s; m4.a = a; m4.b = b;
    @(negedge Clk);
    m4.start = 1'b0; m4.a = 4'h0; m4.b = 4'h0; m4.sgn = 1'b0;
    wait_done4(got, bc);
    checks++;
    if (got !== 1) begin errors++; $display("FAIL %s done: seen %0d want 1", name, got); end
    checks++;
    if (bc !== 4) begin errors++; $display("FAIL %s busy_cycles: got %0d want 4", name, bc); end
    checks++;
    if (m4.out !== exp) begin errors++; $display("FAIL %s out: got %h want %h", name, m4.out, exp); end
    @(negedge Clk);
    checks++;
    if (m4.done !== 1'b0 || m4.out !== exp) begin
      errors++; $display("FAIL %s hold: done %b out %h want 0 %h", name, m4.done, m4.out, exp);
    end
  endtask

  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input string name);
    int got, bc, cyc;
    @(negedge Clk);
    m8.start = 1'b1; m8.sgn = s; m8.a = a; m8.b = b;
    @(negedge Clk);
    m8.start = 1'b0; m8.a = 8'h0; m8.b = 8'h0; m8.sgn = 1'b0;
    got = 0; bc = 0; cyc = 0;
    while (cyc < 30 && got == 0) begin
      if (m8.done === 1'b1) got = 1;
      else begin
        if (m8.busy === 1'b1) bc++;
        @(negedge Clk);
        cyc++;
      end
    end
    checks++;
    if (got !== 1) begin errors++; $display("FAIL %s done: seen %0d want 1", name, got); end
    checks++;
    if (bc !== 8) begin errors++; $display("FAIL %s busy_cycles: got %0d want 8", name, bc); end
    checks++;
    if (m8.out !== exp) begin errors++; $display("FAIL %s out: got %h want %h", name, m8.out, exp); end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    checks++;
    if (m4.busy !== 1'b0 || m4.done !== 1'b0 || m4.out !== 8'h00) begin
      errors++; $display("FAIL reset4: busy %b done %b out %h want 0 0 00", m4.busy, m4.done, m4.out);
    end
    checks++;
    if (m8.busy !== 1'b0 || m8.done !== 1'b0 || m8.out !== 16'h0000) begin
      errors++; $display("FAIL reset8: busy %b done %b out %h want 0 0 0000", m8.busy, m8.done, m8.out);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run4(1'b0, 4'd3, 4'd5, 8'h0F, "basic_3x5");
  endtask

  task automatic test_unsigned();
    run4(1'b0, 4'd11, 4'd14, 8'h9A, "u_11x14");
    run4(1'b0, 4'd4,  4'd12, 8'h30, "u_4x12");
    run4(1'b0, 4'hF,  4'hF,  8'hE1, "u_15x15");
  endtask

  task automatic test_signed();
    run4(1'b1, 4'hD, 4'h5, 8'hF1, "s_m3x5");
    run4(1'b1, 4'h8, 4'h8, 8'h40, "s_m8xm8");
    run4(1'b1, 4'h8, 4'h7, 8'hC8, "s_m8x7");
    run4(1'b1, 4'h3, 4'h0, 8'h00, "s_3x0");
  endtask

  task automatic test_back_to_back();
    int got, bc;
    @(negedge Clk);
    m4.start = 1'b1; m4.sgn = 1'b0; m4.a = 4'd2; m4.b = 4'd3;
    @(negedge Clk);
    m4.start = 1'b0; m4.a = 4'd0; m4.b = 4'd0;
    @(negedge Clk);
    m4.start = 1'b1; m4.a = 4'd15; m4.b = 4'd15;
    @(negedge Clk);
    m4.start = 1'b0;
    wait_done4(got, bc);
    checks++;
    if (got !== 1 || m4.out !== 8'h06) begin
      errors++; $display("FAIL ignore_busy: done %0d out %h want 1 06", got, m4.out);
    end
    // start in the done cycle must be accepted
    m4.start = 1'b1; m4.a = 4'd5; m4.b = 4'd6;
    @(negedge Clk);
    m4.start = 1'b0; m4.a = 4'd0; m4.b = 4'd0;
    checks++;
    if (m4.busy !== 1'b1 || m4.done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: busy %b done %b want 1 0", m4.busy, m4.done);
    end
    wait_done4(got, bc);
    checks++;
    if (got !== 1 || bc !== 4 || m4.out !== 8'h1E) begin
      errors++; $display("FAIL b2b_result: done %0d busy %0d out %h want 1 4 1E", got, bc, m4.out);
    end
  endtask

  task automatic test_reset_midop();
    int nd;
    @(negedge Clk);
    m4.start = 1'b1; m4.sgn = 1'b0; m4.a = 4'd7; m4.b = 4'd7;
    @(negedge Clk);
    m4.start = 1'b0;
    @(negedge Clk);
    rst = 1'b1;
    @(negedge Clk);
    checks++;
    if (m4.busy !== 1'b0 || m4.out !== 8'h00 || m4.done !== 1'b0) begin
      errors++; $display("FAIL midop_reset: busy %b out %h done %b want 0 00 0", m4.busy, m4.out, m4.done);
    end
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (m4.done === 1'b1) nd++;
    end
    checks++;
    if (nd !== 0 || m4.out !== 8'h00) begin
      errors++; $display("FAIL midop_nodone: dones %0d out %h want 0 00", nd, m4.out);
    end
  endtask

  task automatic test_n8();
    run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "n8_255x255");
    run8(1'b1, 8'h80, 8'hFF, 16'h0080, "n8_m128xm1");
    run8(1'b1, 8'h80, 8'h80, 16'h4000, "n8_m128xm128");
  endtask

  initial begin
    m4.start = 1'b0; m4.sgn = 1'b0; m4.a = '0; m4.b = '0;
    m8.start = 1'b0; m8.sgn = 1'b0; m8.a = '0; m8.b = '0;
    test_reset();
    test_basic();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_reset_midop();
    test_n8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
